// File: rtl/median_col_sort_if.sv
// Column-sorter handshake bundle: input column stream, sorted output stream and occupancy.
interface median_col_sort_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 3
);
  logic [WIN_SIZE*DATA_WIDTH-1:0] win_pix;
  logic                           win_val;
  logic                           win_rdy;
  logic                           win_sol;
  logic                           win_eol;
  logic                           win_sof;
  logic                           win_eof;
  logic                           sort_val;
  logic                           sort_rdy;
  logic                           sort_sol;
  logic                           sort_eol;
  logic                           sort_sof;
  logic                           sort_eof;
  logic [WIN_SIZE*DATA_WIDTH-1:0] sort_data;
  logic [DATA_WIDTH-1:0]          sort_med;
  logic [2:0]                     pipe_cnt;

  modport slave (
    input  win_pix, win_val, win_sol, win_eol, win_sof, win_eof, sort_rdy,
    output win_rdy, sort_val, sort_sol, sort_eol, sort_sof, sort_eof,
           sort_data, sort_med, pipe_cnt
  );

  modport master (
    output win_pix, win_val, win_sol, win_eol, win_sof, win_eof, sort_rdy,
    input  win_rdy, sort_val, sort_sol, sort_eol, sort_sof, sort_eof,
           sort_data, sort_med, pipe_cnt
  );
endinterface

// File: rtl/median_col_sort.sv
// Pipelined odd-even transposition sorter for one pixel column; emits the sorted
// column and its median with valid/ready flow control on both sides.
module median_col_sort #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN_SIZE   = 3
) (
  input logic              clk,
  input logic              rst_n,
  median_col_sort_if.slave io_bus
);
  localparam int LW   = WIN_SIZE * DATA_WIDTH;
  localparam int LAST = WIN_SIZE - 1;
  localparam int MED  = (WIN_SIZE - 1) / 2;

  if (!(WIN_SIZE == 3 || WIN_SIZE == 5)) begin : g_bad_win
    $error("median_col_sort: WIN_SIZE must be 3 or 5");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
    $error("median_col_sort: DATA_WIDTH must be 1..16");
  end

  logic                r_val  [WIN_SIZE];
  logic [LW-1:0]       r_data [WIN_SIZE];
  logic [3:0]          r_flg  [WIN_SIZE];
  logic [2:0]          r_cnt;

  logic [WIN_SIZE-1:0] w_src_val;
  logic [LW-1:0]       w_src     [WIN_SIZE];
  logic [3:0]          w_src_flg [WIN_SIZE];
  logic [LW-1:0]       w_nxt     [WIN_SIZE];
  logic [WIN_SIZE-1:0] w_load;
  logic [WIN_SIZE-1:0] w_adv;

  always_comb begin
    w_src_val[0] = io_bus.win_val;
    w_src[0]     = io_bus.win_pix;
    w_src_flg[0] = {io_bus.win_eof, io_bus.win_eol, io_bus.win_sof, io_bus.win_sol};
    for (int k = 1; k < WIN_SIZE; k++) begin
      w_src_val[k] = r_val[k-1];
      w_src[k]     = r_data[k-1];
      w_src_flg[k] = r_flg[k-1];
    end
  end

  // Ready ripples back from the output: resolve the last stage first.
  always_comb begin
    w_adv        = '0;
    w_load       = '0;
    w_adv[LAST]  = r_val[LAST] & io_bus.sort_rdy;
    w_load[LAST] = w_src_val[LAST] & (~r_val[LAST] | w_adv[LAST]);
    for (int k = LAST - 1; k >= 0; k--) begin
      w_adv[k]  = r_val[k] & w_load[k+1];
      w_load[k] = w_src_val[k] & (~r_val[k] | w_adv[k]);
    end
  end

  // Even stages compare pairs (0,1),(2,3)..; odd stages (1,2),(3,4)..; ties never swap.
  always_comb begin
    for (int k = 0; k < WIN_SIZE; k++) begin
      w_nxt[k] = w_src[k];
      for (int i = k % 2; i < LAST; i += 2) begin
        if (w_src[k][i*DATA_WIDTH +: DATA_WIDTH] > w_src[k][(i+1)*DATA_WIDTH +: DATA_WIDTH]) begin
          w_nxt[k][i*DATA_WIDTH +: DATA_WIDTH]     = w_src[k][(i+1)*DATA_WIDTH +: DATA_WIDTH];
          w_nxt[k][(i+1)*DATA_WIDTH +: DATA_WIDTH] = w_src[k][i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WIN_SIZE; k++) begin
        r_val[k]  <= 1'b0;
        r_data[k] <= '0;
        r_flg[k]  <= '0;
      end
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < WIN_SIZE; k++) begin
        if (w_load[k]) begin
          r_val[k]  <= 1'b1;
          r_data[k] <= w_nxt[k];
          r_flg[k]  <= w_src_flg[k];
        end else if (w_adv[k]) begin
          r_val[k]  <= 1'b0;
        end
      end
      r_cnt <= r_cnt + 3'(w_load[0]) - 3'(w_adv[LAST]);
    end
  end

  assign io_bus.win_rdy   = ~r_val[0] | w_adv[0];
  assign io_bus.sort_val  = r_val[LAST];
  assign io_bus.sort_data = r_data[LAST];
  assign io_bus.sort_med  = r_data[LAST][MED*DATA_WIDTH +: DATA_WIDTH];
  assign io_bus.sort_sol  = r_flg[LAST][0];
  assign io_bus.sort_sof  = r_flg[LAST][1];
  assign io_bus.sort_eol  = r_flg[LAST][2];
  assign io_bus.sort_eof  = r_flg[LAST][3];
  assign io_bus.pipe_cnt  = r_cnt;

endmodule

// File: tb/tb_median_col_sort.sv
// Bench for median_col_sort: WIN_SIZE=3 and WIN_SIZE=5 instances checked against a
// sort-and-queue model every cycle, plus hand-computed literal expectations.
module tb_median_col_sort;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  median_col_sort_if #(.DATA_WIDTH(8), .WIN_SIZE(3)) if3 ();
  median_col_sort_if #(.DATA_WIDTH(8), .WIN_SIZE(5)) if5 ();

  median_col_sort #(.DATA_WIDTH(8), .WIN_SIZE(3)) dut3 (.clk(clk), .rst_n(rst_n), .io_bus(if3.slave));
  median_col_sort #(.DATA_WIDTH(8), .WIN_SIZE(5)) dut5 (.clk(clk), .rst_n(rst_n), .io_bus(if5.slave));

  typedef struct {
    logic [39:0] d;
    logic [3:0]  f;
    int          te;
  } exp_t;

  exp_t sb [2][16];
  int   hd [2] = '{0, 0};
  int   tl [2] = '{0, 0};
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain ascending sort of the first w lanes.
  function automatic logic [39:0] sort_col(input logic [39:0] c, input int w);
    int v[5];
    int t;
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < w; i++) v[i] = int'(c[i*8 +: 8]);
    for (int i = 0; i < w; i++)
      for (int j = i + 1; j < w; j++)
        if (v[j] < v[i]) begin t = v[i]; v[i] = v[j]; v[j] = t; end
    for (int i = 0; i < w; i++) r[i*8 +: 8] = 8'(v[i]);
    return r;
  endfunction

  task automatic chk_dut(input int n, input int w, input logic vin, input logic [39:0] pix,
                         input logic [3:0] fin, input logic rdy, input logic sval, input logic srdy,
                         input logic [39:0] sd, input logic [7:0] med, input logic [3:0] sf,
                         input logic [2:0] cnt);
    int    occ;
    logic  ev;
    exp_t  e;
    string p;
    p   = $sformatf("w%0d_", w);
    occ = tl[n] - hd[n];
    if (!rst_n) begin
      check({p, "rst_sort_val"},  64'(sval), 64'(0));
      check({p, "rst_sort_data"}, 64'(sd),   64'(0));
      check({p, "rst_sort_med"},  64'(med),  64'(0));
      check({p, "rst_flags"},     64'(sf),   64'(0));
      check({p, "rst_pipe_cnt"},  64'(cnt),  64'(0));
      check({p, "rst_win_rdy"},   64'(rdy),  64'(1));
      hd[n] = 0;
      tl[n] = 0;
      return;
    end
    check({p, "pipe_cnt"}, 64'(cnt), 64'(occ));
    check({p, "win_rdy"},  64'(rdy), (occ == w && !srdy) ? 64'(0) : 64'(1));
    e  = sb[n][hd[n] % 16];
    ev = (occ > 0) && (cyc >= e.te + w - 1);
    check({p, "sort_val"}, 64'(sval), 64'(ev));
    if (ev) begin
      check({p, "sort_data"}, 64'(sd),  64'(e.d));
      check({p, "sort_med"},  64'(med), 64'(e.d[((w-1)/2)*8 +: 8]));
      check({p, "sort_flags"}, 64'(sf), 64'(e.f));
      if (srdy) hd[n]++;
    end
    if (vin && rdy) begin
      sb[n][tl[n] % 16] = '{d: sort_col(pix, w), f: fin, te: cyc + 1};
      tl[n]++;
    end
  endtask

  always @(negedge clk) begin
    chk_dut(0, 3, if3.win_val, {16'h0, if3.win_pix},
            {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol}, if3.win_rdy,
            if3.sort_val, if3.sort_rdy, {16'h0, if3.sort_data}, if3.sort_med,
            {if3.sort_eof, if3.sort_eol, if3.sort_sof, if3.sort_sol}, if3.pipe_cnt);
    chk_dut(1, 5, if5.win_val, if5.win_pix,
            {if5.win_eof, if5.win_eol, if5.win_sof, if5.win_sol}, if5.win_rdy,
            if5.sort_val, if5.sort_rdy, if5.sort_data, if5.sort_med,
            {if5.sort_eof, if5.sort_eol, if5.sort_sof, if5.sort_sol}, if5.pipe_cnt);
  end

  task automatic send3(input logic [23:0] pix, input logic [3:0] f);
    int n;
    n = 0;
    if3.win_pix = pix;
    {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = f;
    if3.win_val = 1'b1;
    @(negedge clk);
    while (!if3.win_rdy && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("send3_win_rdy_timeout", 64'(if3.win_rdy), 64'(1));
    @(posedge clk); #1;
    if3.win_val = 1'b0;
    {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = 4'b0;
  endtask

  task automatic send5(input logic [39:0] pix);
    int n;
    n = 0;
    if5.win_pix = pix;
    if5.win_val = 1'b1;
    @(negedge clk);
    while (!if5.win_rdy && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("send5_win_rdy_timeout", 64'(if5.win_rdy), 64'(1));
    @(posedge clk); #1;
    if5.win_val = 1'b0;
  endtask

  logic [23:0] bp [7] = '{24'h0a0507, 24'h010203, 24'h030201, 24'hff00ff,
                          24'h808080, 24'h7f807e, 24'h00ff10};
  logic [23:0] fcol [4] = '{24'h112233, 24'h332211, 24'h221133, 24'h000000};
  logic [3:0]  fl [4];

  initial begin
    int nb;
    int idx;
    int c;
    logic [39:0] r5;
    if3.win_pix = '0; if3.win_val = 0; if3.sort_rdy = 1;
    {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = 4'b0;
    if5.win_pix = '0; if5.win_val = 0; if5.sort_rdy = 1;
    {if5.win_eof, if5.win_eol, if5.win_sof, if5.win_sol} = 4'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_win_rdy",  64'(if3.win_rdy),  64'(1));
    check("reset_pipe_cnt", 64'(if3.pipe_cnt), 64'(0));
    check("reset_sort_val", 64'(if3.sort_val), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic column, three-cycle latency
    send3(24'h103020, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check("basic_sort_val",  64'(if3.sort_val),  64'(1));
    check("basic_sort_data", 64'(if3.sort_data), 64'h302010);
    check("basic_sort_med",  64'(if3.sort_med),  64'h20);

    send3(24'h114444, 4'b0);
    repeat (2) @(posedge clk);
    #1;
    check("ties_sort_data", 64'(if3.sort_data), 64'h444411);
    check("ties_sort_med",  64'(if3.sort_med),  64'h44);
    @(posedge clk); #1;

    // Four-beat stream with frame/line flags, captured as it leaves
    nb = 0;
    for (int b = 0; b < 8; b++) begin
      if (b < 4) begin
        if3.win_pix = fcol[b];
        if3.win_val = 1'b1;
        {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} =
          (b == 0) ? 4'b0011 : (b == 3) ? 4'b1100 : 4'b0000;
      end else begin
        if3.win_val = 1'b0;
        {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = 4'b0;
      end
      @(posedge clk); #1;
      if (if3.sort_val && nb < 4) begin
        fl[nb] = {if3.sort_eof, if3.sort_eol, if3.sort_sof, if3.sort_sol};
        nb++;
      end
    end
    check("flags_beats", 64'(nb),    64'(4));
    check("flags_beat1", 64'(fl[0]), 64'b0011);
    check("flags_beat2", 64'(fl[1]), 64'b0000);
    check("flags_beat3", 64'(fl[2]), 64'b0000);
    check("flags_beat4", 64'(fl[3]), 64'b1100);

    // Backpressure: offer 7 columns with the output stalled
    if3.sort_rdy = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if3.win_pix = bp[idx];
      if3.win_val = 1'b1;
      @(negedge clk);
      if (if3.win_rdy && idx < 6) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted",  64'(idx),           64'(3));
    check("bp_win_rdy",   64'(if3.win_rdy),   64'(0));
    check("bp_pipe_cnt",  64'(if3.pipe_cnt),  64'(3));
    check("bp_head_data", 64'(if3.sort_data), 64'h0a0705);
    repeat (2) @(posedge clk);
    #1;
    check("bp_head_stable", 64'(if3.sort_data), 64'h0a0705);
    check("bp_head_med",    64'(if3.sort_med),  64'h07);
    if3.sort_rdy = 1'b1;
    c = 0;
    while (idx < 7 && c < 60) begin
      if3.win_pix = bp[idx];
      if3.win_val = 1'b1;
      @(negedge clk);
      if (if3.win_rdy) idx++;
      @(posedge clk); #1;
      if (c == 0) check("bp_cnt_full_swap", 64'(if3.pipe_cnt), 64'(3));
      c++;
    end
    if3.win_val = 1'b0;
    check("bp_all_accepted", 64'(idx), 64'(7));
    repeat (5) @(posedge clk);
    #1;
    check("bp_drained", 64'(if3.pipe_cnt), 64'(0));

    // WIN_SIZE=5: reverse order and ties
    send5(40'h0103050709);
    repeat (4) @(posedge clk);
    #1;
    check("w5_sort_data", 64'(if5.sort_data), 64'h0907050301);
    check("w5_sort_med",  64'(if5.sort_med),  64'h05);
    send5(40'h3333113333);
    repeat (4) @(posedge clk);
    #1;
    check("w5_ties_data", 64'(if5.sort_data), 64'h3333333311);
    check("w5_ties_med",  64'(if5.sort_med),  64'h33);
    @(posedge clk); #1;

    // Random traffic with random output stalls on both widths
    for (int k = 0; k < 80; k++) begin
      for (int l = 0; l < 5; l++) r5[l*8 +: 8] = 8'($urandom_range(0, 15));
      if5.win_pix  = r5;
      if5.win_val  = 1'($urandom_range(0, 1));
      if5.sort_rdy = ($urandom_range(0, 3) != 0);
      {if5.win_eof, if5.win_eol, if5.win_sof, if5.win_sol} = 4'($urandom_range(0, 15));
      for (int l = 0; l < 3; l++) r5[l*8 +: 8] = 8'($urandom_range(0, 255));
      if3.win_pix  = r5[23:0];
      if3.win_val  = 1'($urandom_range(0, 1));
      if3.sort_rdy = 1'($urandom_range(0, 1));
      {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    if3.win_val = 1'b0; if3.sort_rdy = 1'b1;
    if5.win_val = 1'b0; if5.sort_rdy = 1'b1;
    {if3.win_eof, if3.win_eol, if3.win_sof, if3.win_sol} = 4'b0;
    {if5.win_eof, if5.win_eol, if5.win_sof, if5.win_sol} = 4'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset with two columns in flight
    if3.win_pix = 24'h050403; if3.win_val = 1'b1;
    @(posedge clk); #1;
    if3.win_pix = 24'h090807;
    @(posedge clk); #1;
    if3.win_val = 1'b0;
    @(posedge clk); #1;
    check("inflight_sort_val", 64'(if3.sort_val), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_sort_val",  64'(if3.sort_val),  64'(0));
    check("midrst_pipe_cnt",  64'(if3.pipe_cnt),  64'(0));
    check("midrst_win_rdy",   64'(if3.win_rdy),   64'(1));
    check("midrst_sort_data", 64'(if3.sort_data), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("postrst_no_stale", 64'(if3.sort_val), 64'(0));
    end
    send3(24'h203010, 4'b0);
    @(posedge clk); #1;
    check("postrst_not_early", 64'(if3.sort_val), 64'(0));
    @(posedge clk); #1;
    check("postrst_sort_val",  64'(if3.sort_val),  64'(1));
    check("postrst_sort_data", 64'(if3.sort_data), 64'h302010);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/median_col_sort.md
MEDIAN_COL_SORT -- requirements
Module: median_col_sort

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits, legal range 1..16.
REQ-002 Parameter WIN_SIZE, default 3: pixels per column, legal values 3 or 5; any other value shall stop elaboration.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port win_pix, input, WIN_SIZE*DATA_WIDTH bits: column pixels; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 Ports win_val (input, 1) and win_rdy (output, 1): input handshake; a transfer occurs when both are high on a clock edge.
REQ-007 Ports win_sol, win_eol, win_sof, win_eof, input, 1 bit each: start/end of line/frame flags, qualified by win_val.
REQ-008 Ports sort_val (output, 1) and sort_rdy (input, 1): output handshake; a transfer occurs when both are high.
REQ-009 Ports sort_sol, sort_eol, sort_sof, sort_eof, output, 1 bit each: flags aligned with sort_data.
REQ-010 Port sort_data, output, WIN_SIZE*DATA_WIDTH bits: sorted column; lane 0 holds the minimum, lane WIN_SIZE-1 the maximum.
REQ-011 Port sort_med, output, DATA_WIDTH bits: the median, equal to lane (WIN_SIZE-1)/2 of sort_data.
REQ-012 Port pipe_cnt, output, 3 bits: number of occupied pipeline stages, 0..WIN_SIZE.

Function
REQ-013 Sorting shall be an odd-even transposition network of WIN_SIZE registered stages; stage k compares lane pairs (i,i+1) with i even when k is even and i odd when k is odd.
REQ-014 Each compare shall swap only when lane i is strictly greater than lane i+1; equal values shall not swap.
REQ-015 Each stage shall hold a valid bit, WIN_SIZE lanes and four flag bits; flags shall travel unchanged with their data.
REQ-016 Stage k shall load when its upstream source is valid and stage k is empty or advancing; stage k advances when it is valid and stage k+1 loads, or, for the last stage, when sort_rdy is high.
REQ-017 win_rdy shall be combinational: high when stage 0 is empty or advancing.
REQ-018 The outputs sort_val, sort_data, sort_med and the sort_* flags shall come directly from the last-stage registers.
REQ-019 Latency shall be WIN_SIZE cycles from an input transfer to sort_val with no backpressure.
REQ-020 With sort_rdy held high, the block shall accept one input per cycle with no bubbles.
REQ-021 While sort_val is high and sort_rdy is low, sort_data, sort_med and the flags shall remain stable.
REQ-022 A stage that is not loading shall hold its contents; a stage that advances without loading shall clear its valid bit.
REQ-023 pipe_cnt shall equal the registered sum of the stage valid bits.
REQ-024 Filling under backpressure: once all WIN_SIZE stages are valid and sort_rdy is low, win_rdy shall be low.
REQ-025 Simultaneous input and output transfers on a full pipe shall leave pipe_cnt unchanged and lose no data.

Reset
REQ-026 While rst_n is low:
- all stage valid bits, lanes and flags shall be 0;
- sort_val = 0 and sort_data = 0;
- sort_med = 0 and all sort_* flags = 0;
- pipe_cnt = 0;
- win_rdy = 1.
REQ-027 Asserting reset mid-operation shall discard all in-flight columns; the first transfer after release shall behave as on an empty pipe.

Verification
REQ-028 WIN_SIZE=3, DATA_WIDTH=8, sort_rdy=1; input lanes {2:0x10, 1:0x30, 0:0x20} -> after 3 cycles sort_val=1, sort_data=0x302010, sort_med=0x20.
REQ-029 WIN_SIZE=5; input lanes 0..4 = 9,7,5,3,1 -> after 5 cycles lanes 0..4 = 1,3,5,7,9 and sort_med=5.
REQ-030 Ties, WIN_SIZE=3: lanes 0..2 = 0x44,0x44,0x11 -> sort_data=0x444411, sort_med=0x44.
REQ-031 Backpressure: sort_rdy=0 while 7 columns are offered:
- exactly WIN_SIZE columns are accepted;
- win_rdy then drops to 0 and pipe_cnt=WIN_SIZE;
- after sort_rdy rises, all 7 columns emerge in order, each stable while stalled.
REQ-032 Flags: win_sof=1 and win_sol=1 on the first beat, win_eol=1 and win_eof=1 on the last beat of a 4-beat stream -> sort_sof/sort_sol appear only on output beat 1, sort_eol/sort_eof only on beat 4.
REQ-033 Reset with 2 columns in flight -> sort_val=0 and pipe_cnt=0 immediately, win_rdy=1; no stale column appears after release.
